// File: rtl/e_pkg.sv
// Shared types and helpers for the elevator call scheduler.
// Floor vectors are widened to vec_t so the mask helpers work for any car height.
package e_pkg;

    localparam int NFLR_DEF = 4;
    localparam int VW       = 32;

    typedef logic [VW-1:0] vec_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECIDE = 2'd1,
        S_TRAVEL = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    function automatic logic onehot_ok(input vec_t v);
        return $onehot(v);
    endfunction

    // Bits strictly below the single set bit of cur.
    function automatic vec_t below_mask(input vec_t cur);
        return cur - vec_t'(1);
    endfunction

    // Bits strictly above the single set bit of cur.
    function automatic vec_t above_mask(input vec_t cur);
        return ~(cur | (cur - vec_t'(1)));
    endfunction

endpackage

// File: rtl/e_req_latch.sv
// Pending-call register: presses set bits, a served floor clears its bit.
// A clear on the same edge as a press at that floor wins.
module e_req_latch #(
    parameter int NFLR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NFLR-1:0] set_vec,
    input  logic [NFLR-1:0] clr_vec,
    output logic [NFLR-1:0] pending
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_vec) & ~clr_vec;
        end
    end

endmodule

// File: rtl/e_call_scheduler.sv
// SCAN request scheduler: latches calls, picks direction, drives the car
// state machine with move/stop requests and clears calls once served.
module e_call_scheduler
    import e_pkg::*;
#(
    parameter int NFLR = NFLR_DEF,
    parameter int TMO  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NFLR-1:0] bts,
    input  logic [NFLR-1:0] curFlr,
    input  logic            arrived,
    input  logic            car_done,
    output logic            move_req,
    output logic            dir_up,
    output logic            stop_req,
    output logic [NFLR-1:0] pending,
    output logic            err
);

    localparam int CW = $clog2(TMO);

    state_t          state;
    state_t          state_nx;
    logic            dir_q;
    logic            dir_nx;
    logic            err_q;
    logic            err_nx;
    logic [CW-1:0]   tmo_cnt;
    vec_t            cur_v;
    vec_t            pend_v;
    vec_t            abv_v;
    vec_t            blw_v;
    logic            valid;
    logic            above;
    logic            below;
    logic            here;
    logic            ahead;
    logic            enter_stop;
    logic [NFLR-1:0] clr_vec;

    always_comb begin
        cur_v              = '0;
        cur_v[NFLR-1:0]    = curFlr;
        pend_v             = '0;
        pend_v[NFLR-1:0]   = pending;
        abv_v              = above_mask(cur_v) & pend_v;
        blw_v              = below_mask(cur_v) & pend_v;
    end

    assign valid = onehot_ok(cur_v);
    assign above = |abv_v;
    assign below = |blw_v;
    assign here  = |(pending & curFlr);
    assign ahead = dir_q ? above : below;

    always_comb begin
        state_nx = state;
        dir_nx   = dir_q;
        err_nx   = err_q;
        if (!valid) begin
            state_nx = S_IDLE;
            err_nx   = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (here) begin
                        state_nx = S_STOP;
                    end else if (above || below) begin
                        state_nx = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    // Keep heading while calls lie ahead, otherwise reverse.
                    dir_nx   = (dir_q & above) | (~below & above) | (dir_q & ~below);
                    state_nx = S_TRAVEL;
                end
                S_TRAVEL: begin
                    if (arrived) begin
                        if (here) begin
                            state_nx = S_STOP;
                        end else if (!ahead) begin
                            state_nx = S_DECIDE;
                        end
                    end
                end
                S_STOP: begin
                    if (tmo_cnt == CW'(TMO - 1)) begin
                        err_nx   = 1'b1;
                        state_nx = S_IDLE;
                    end else if (car_done && (tmo_cnt != '0)) begin
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    assign enter_stop = (state_nx == S_STOP) && (state != S_STOP);
    assign clr_vec    = enter_stop ? curFlr : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nx;
            dir_q <= dir_nx;
            err_q <= err_nx;
            if ((state == S_STOP) && (state_nx == S_STOP)) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    e_req_latch #(
        .NFLR(NFLR)
    ) u_req_latch (
        .clk(clk),
        .rst_n(rst_n),
        .set_vec(bts),
        .clr_vec(clr_vec),
        .pending(pending)
    );

    assign move_req = (state == S_TRAVEL);
    assign stop_req = (state == S_STOP) && (tmo_cnt == '0);
    assign dir_up   = dir_q;
    assign err      = err_q;

endmodule

// File: tb/tb_e_call_scheduler.sv
// Bench for e_call_scheduler: directed scenarios plus a randomized car
// environment, all outputs checked every cycle against a floor-level model.
module tb_e_call_scheduler;

    localparam int NFLR = 4;
    localparam int TMO  = 64;

    localparam int M_IDLE   = 10;
    localparam int M_DECIDE = 11;
    localparam int M_TRAVEL = 12;
    localparam int M_STOP   = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NFLR-1:0] bts = '0;
    logic [NFLR-1:0] curFlr = 4'b0001;
    logic            arrived = 1'b0;
    logic            car_done = 1'b0;
    logic            move_req;
    logic            dir_up;
    logic            stop_req;
    logic [NFLR-1:0] pending;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;

    bit [NFLR-1:0] m_pend = '0;
    int            m_mode = M_IDLE;
    bit            m_dir  = 1'b1;
    bit            m_err  = 1'b0;
    int            m_stopc = 0;

    e_call_scheduler #(
        .NFLR(NFLR),
        .TMO(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bts(bts),
        .curFlr(curFlr),
        .arrived(arrived),
        .car_done(car_done),
        .move_req(move_req),
        .dir_up(dir_up),
        .stop_req(stop_req),
        .pending(pending),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Floor-level view of the scheduler: calls as a set, SCAN by floor index.
    task automatic model_edge();
        int  cf;
        bit  ok;
        bit  abv;
        bit  blw;
        bit  hr;
        int  nmode;
        if (!rst_n) begin
            m_pend  = '0;
            m_mode  = M_IDLE;
            m_dir   = 1'b1;
            m_err   = 1'b0;
            m_stopc = 0;
            return;
        end
        ok = ($countones(curFlr) == 1);
        cf = 0;
        for (int f = 0; f < NFLR; f++) if (curFlr[f]) cf = f;
        abv = 1'b0;
        blw = 1'b0;
        for (int f = 0; f < NFLR; f++) begin
            if (m_pend[f] && f > cf) abv = 1'b1;
            if (m_pend[f] && f < cf) blw = 1'b1;
        end
        hr    = ok && m_pend[cf];
        nmode = m_mode;
        if (!ok) begin
            nmode = M_IDLE;
            m_err = 1'b1;
        end else if (m_mode == M_IDLE) begin
            if (hr) nmode = M_STOP;
            else if (abv || blw) nmode = M_DECIDE;
        end else if (m_mode == M_DECIDE) begin
            if (abv && !blw) m_dir = 1'b1;
            else if (blw && !abv) m_dir = 1'b0;
            nmode = M_TRAVEL;
        end else if (m_mode == M_TRAVEL) begin
            if (arrived) begin
                if (hr) nmode = M_STOP;
                else if (!(m_dir ? abv : blw)) nmode = M_DECIDE;
            end
        end else begin
            if (m_stopc == TMO - 1) begin
                m_err = 1'b1;
                nmode = M_IDLE;
            end else if (car_done && m_stopc >= 1) begin
                nmode = M_IDLE;
            end
        end
        m_pend = m_pend | bts;
        if (nmode == M_STOP && m_mode != M_STOP) m_pend[cf] = 1'b0;
        m_stopc = (nmode == M_STOP && m_mode == M_STOP) ? m_stopc + 1 : 0;
        m_mode  = nmode;
    endtask

    task automatic compare_all();
        check("pending", 32'(pending), 32'(m_pend));
        check("move_req", 32'(move_req), 32'(m_mode == M_TRAVEL));
        check("dir_up", 32'(dir_up), 32'(m_dir));
        check("stop_req", 32'(stop_req), 32'(m_mode == M_STOP && m_stopc == 0));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic visit(input logic [NFLR-1:0] fl);
        curFlr = fl;
        tick();
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
    endtask

    task automatic finish_stop();
        car_done = 1'b1;
        tick();
        tick();
        car_done = 1'b0;
    endtask

    int floor_i;
    int tcnt;
    bit arr_next;
    int done_wait;

    initial begin
        // Scenario 1: reset, latency, pass-through floors, stop at call.
        rst_n = 1'b0;
        tick();
        check("rst_pending", 32'(pending), 0);
        check("rst_dir", 32'(dir_up), 1);
        check("rst_move", 32'(move_req), 0);
        rst_n = 1'b1;
        bts = 4'b1000;
        tick();
        bts = '0;
        check("s1_latched", 32'(pending), 8);
        tick();
        check("s1_e1_move", 32'(move_req), 0);
        tick();
        check("s1_e2_move", 32'(move_req), 1);
        check("s1_e2_dir", 32'(dir_up), 1);
        visit(4'b0010);
        check("s1_pass1", 32'(stop_req), 0);
        visit(4'b0100);
        check("s1_pass2", 32'(stop_req), 0);
        visit(4'b1000);
        check("s1_stop", 32'(stop_req), 1);
        check("s1_clear", 32'(pending), 0);
        check("s1_halt", 32'(move_req), 0);
        finish_stop();

        // Scenario 2: call behind the car served after reaching the top.
        curFlr = 4'b0010;
        bts = 4'b1000;
        tick();
        bts = '0;
        tick();
        tick();
        bts = 4'b0001;
        tick();
        bts = '0;
        visit(4'b0100);
        visit(4'b1000);
        check("s2_top_stop", 32'(stop_req), 1);
        check("s2_left", 32'(pending), 1);
        finish_stop();
        tick();
        tick();
        check("s2_dir_down", 32'(dir_up), 0);
        check("s2_moving", 32'(move_req), 1);
        visit(4'b0100);
        visit(4'b0010);
        visit(4'b0001);
        check("s2_bot_stop", 32'(stop_req), 1);
        finish_stop();

        // Scenario 3: press at served floor on the stop-entry edge is absorbed.
        curFlr = 4'b0100;
        tick();
        bts = 4'b0100;
        tick();
        bts = 4'b0101;
        tick();
        bts = '0;
        check("s3_absorb", 32'(pending), 1);
        check("s3_stop", 32'(stop_req), 1);
        finish_stop();

        // Scenario 4: bad floor vector mid-travel, then recovery.
        tick();
        tick();
        check("s4_travel", 32'(move_req), 1);
        curFlr = 4'b0110;
        tick();
        check("s4_err", 32'(err), 1);
        check("s4_halt", 32'(move_req), 0);
        curFlr = 4'b0100;
        tick();
        tick();
        check("s4_resume", 32'(move_req), 1);
        check("s4_sticky", 32'(err), 1);
        visit(4'b0010);
        visit(4'b0001);
        finish_stop();

        // Scenario 5: door timeout, then reset during travel.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        curFlr = 4'b0001;
        bts = 4'b0001;
        tick();
        bts = '0;
        tick();
        check("s5_stop", 32'(stop_req), 1);
        for (int i = 0; i < TMO - 1; i++) tick();
        check("s5_pre_tmo", 32'(err), 0);
        tick();
        check("s5_tmo_err", 32'(err), 1);
        check("s5_idle", 32'(stop_req | move_req), 0);
        bts = 4'b1000;
        tick();
        bts = '0;
        tick();
        tick();
        check("s5_moving", 32'(move_req), 1);
        rst_n = 1'b0;
        tick();
        check("s5_rst_move", 32'(move_req), 0);
        check("s5_rst_pend", 32'(pending), 0);
        check("s5_rst_err", 32'(err), 0);
        rst_n = 1'b1;

        // Randomized car environment driven from the model's view.
        floor_i   = 0;
        curFlr    = 4'b0001;
        tcnt      = 1;
        arr_next  = 1'b0;
        done_wait = 2;
        for (int c = 0; c < 4000; c++) begin
            rst_n   = ($urandom_range(0, 999) != 0);
            bts     = ($urandom_range(0, 5) == 0) ? NFLR'($urandom) : '0;
            arrived = 1'b0;
            if (m_mode == M_TRAVEL) begin
                if (arr_next) begin
                    arrived  = 1'b1;
                    arr_next = 1'b0;
                end else if (tcnt == 0) begin
                    if (m_dir && floor_i < NFLR - 1) floor_i++;
                    else if (!m_dir && floor_i > 0) floor_i--;
                    arr_next = 1'b1;
                    tcnt     = $urandom_range(0, 2);
                end else begin
                    tcnt--;
                end
            end else begin
                arr_next = 1'b0;
                tcnt     = $urandom_range(0, 2);
                if ($urandom_range(0, 30) == 0) arrived = 1'b1;
            end
            if (m_mode == M_STOP) begin
                car_done = (m_stopc >= done_wait);
            end else begin
                car_done  = 1'($urandom_range(0, 1));
                done_wait = ($urandom_range(0, 15) == 0) ? 100 : $urandom_range(1, 4);
            end
            if ($urandom_range(0, 299) == 0) begin
                curFlr = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1010;
            end else begin
                curFlr = NFLR'(1 << floor_i);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
